// File: rtl/decompression_arbiter_pkg.sv
// decompression_arbiter_pkg: shared sizes, header layout and state encodings for the decompression path
package decompression_arbiter_pkg;
    localparam int PAGE_SIZE       = 4096;
    localparam int PAGE_SIZE_WIDTH = $clog2(PAGE_SIZE) + 1;
    localparam int COMP_CORES      = 4;
    localparam int AXI_DATA_BITS   = 512;
    localparam int AXI_KEEP_BITS   = AXI_DATA_BITS / 8;

    typedef logic [PAGE_SIZE_WIDTH-1:0] page_size_t;

    typedef struct packed {
        page_size_t uncom_size;
        page_size_t com_size;
    } dec_hdr_t;

    typedef enum logic [1:0] {IN_HDR, IN_BODY, IN_DROP} in_state_t;
    typedef enum logic [1:0] {GZ_IDLE, GZ_BODY, GZ_WAIT, GZ_EMIT} gz_state_t;

    function automatic logic size_ok(page_size_t s);
        return (s != '0) && (s <= page_size_t'(PAGE_SIZE));
    endfunction

    function automatic page_size_t keep_bytes(logic [AXI_KEEP_BITS-1:0] k);
        return page_size_t'($countones(k));
    endfunction
endpackage

// File: rtl/axi4s.sv
// axi4s: AXI4-Stream bundle; s = sink side, m = source side
interface axi4s #(parameter int DATA_BITS = 512);
    logic [DATA_BITS-1:0]   tdata;
    logic [DATA_BITS/8-1:0] tkeep;
    logic                   tlast;
    logic                   tvalid;
    logic                   tready;
    modport s (input tdata, tkeep, tlast, tvalid, output tready);
    modport m (output tdata, tkeep, tlast, tvalid, input tready);
endinterface

// File: rtl/decompression_arbiter_fifo.sv
// decompression_arbiter_fifo: synchronous FIFO, show-ahead head on o_dout
// Ports: clk, rst (sync, active-high), i_push/i_din, i_pop, o_dout, o_full, o_empty.
// Callers never push when full or pop when empty.
module decompression_arbiter_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [CW-1:0]    r_cnt;

    function automatic logic [AW-1:0] inc(logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wp] <= i_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wp <= inc(r_wp);
            if (i_pop) r_rp <= inc(r_rp);
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_dout  = r_mem[r_rp];
    assign o_full  = r_cnt == CW'(DEPTH);
    assign o_empty = r_cnt == '0;
endmodule

// File: rtl/decompression_arbiter_gunzip.sv
// GunzipWrapper: stand-in gunzip core with a fixed, predictable page generator
// Ports: clk, rst_n (sync, active-low), i_data (compressed body in), o_data (page out).
// The first body beat carries {seed[63:32], delay[31:16], len[PW-1:0]}; the rest of the
// body is absorbed. After the body and `delay` idle cycles it emits `len` bytes as beats
// whose 32-bit words all equal seed+beat_index. One frame at a time.
module GunzipWrapper
    import decompression_arbiter_pkg::*;
(
    input logic clk,
    input logic rst_n,
    axi4s.s     i_data,
    axi4s.m     o_data
);
    localparam int PW = PAGE_SIZE_WIDTH;
    localparam int KB = AXI_KEEP_BITS;
    localparam int KW = $clog2(KB);

    gz_state_t  r_state, w_next;
    page_size_t r_rem;
    logic [15:0] r_dly;
    logic [31:0] r_word;
    logic        w_last, w_in_rdy, w_out_vld;

    assign w_last = r_rem <= page_size_t'(KB);

    always_comb begin
        w_next    = r_state;
        w_in_rdy  = 1'b0;
        w_out_vld = 1'b0;
        case (r_state)
            GZ_IDLE, GZ_BODY: begin
                w_in_rdy = 1'b1;
                if (i_data.tvalid) w_next = i_data.tlast ? GZ_WAIT : GZ_BODY;
            end
            GZ_WAIT: w_next = r_dly == '0 ? GZ_EMIT : GZ_WAIT;
            default: begin
                w_out_vld = 1'b1;
                if (o_data.tready && w_last) w_next = GZ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= GZ_IDLE;
            r_rem   <= '0;
            r_dly   <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == GZ_IDLE && i_data.tvalid) begin
                r_rem  <= i_data.tdata[PW-1:0];
                r_dly  <= i_data.tdata[31:16];
                r_word <= i_data.tdata[63:32];
            end
            if (r_state == GZ_WAIT && r_dly != '0) r_dly <= r_dly - 16'd1;
            if (r_state == GZ_EMIT && o_data.tready) begin
                r_rem  <= w_last ? '0 : r_rem - page_size_t'(KB);
                r_word <= r_word + 32'd1;
            end
        end
    end

    assign i_data.tready = w_in_rdy;
    assign o_data.tvalid = w_out_vld;
    assign o_data.tlast  = w_last;
    assign o_data.tdata  = {(AXI_DATA_BITS/32){r_word}};
    assign o_data.tkeep  = r_rem >= page_size_t'(KB) ? {KB{1'b1}} : (KB'(1) << r_rem[KW-1:0]) - KB'(1);
endmodule

// File: rtl/decompression_arbiter.sv
// decompression_arbiter: parses framed gzip pages, dispatches round-robin to gunzip cores, re-collects in order
// Ports: aclk, areset (sync, active-high), i_data (header beat + body, tlast ends frame),
//        o_data (one page per frame), o_hdr_err/o_clen_err/o_ulen_err (1-cycle registered pulses),
//        o_busy (frames in flight).
module decompression_arbiter
    import decompression_arbiter_pkg::*;
#(
    parameter int N_CORES          = COMP_CORES,
    parameter int ORDER_FIFO_DEPTH = 2 * N_CORES
) (
    input  logic aclk,
    input  logic areset,
    axi4s.s      i_data,
    axi4s.m      o_data,
    output logic o_hdr_err,
    output logic o_clen_err,
    output logic o_ulen_err,
    output logic o_busy
);
    localparam int PW = PAGE_SIZE_WIDTH;
    localparam int SW = N_CORES > 1 ? $clog2(N_CORES) : 1;
    localparam page_size_t CNT_MAX = page_size_t'(PAGE_SIZE + 64);

    in_state_t  r_state, w_state;
    logic [SW-1:0] r_in_sel, w_in_sel, r_out_sel, w_out_sel;
    page_size_t r_in_cnt, w_in_cnt, r_com, w_com, r_out_cnt, w_out_cnt;
    page_size_t w_in_sum, w_out_sum, w_fifo_head;
    logic r_rst_q, w_blk, w_in_rdy, w_push, w_pop, w_fifo_full, w_fifo_empty;
    logic r_hdr_err, r_clen_err, r_ulen_err, w_hdr_err, w_clen_err, w_ulen_err;
    dec_hdr_t w_hdr;
    logic [N_CORES-1:0] w_ci_valid, w_ci_ready, w_co_valid, w_co_ready, w_co_last;
    logic [AXI_DATA_BITS-1:0] w_co_data [N_CORES];
    logic [AXI_KEEP_BITS-1:0] w_co_keep [N_CORES];

    function automatic logic [SW-1:0] wrap(logic [SW-1:0] s);
        return s == SW'(N_CORES - 1) ? '0 : s + SW'(1);
    endfunction

    // r_rst_q keeps both stream interfaces quiet for the cycle following reset
    assign w_blk     = areset | r_rst_q;
    assign w_hdr     = dec_hdr_t'(i_data.tdata[2*PW-1:0]);
    assign w_in_sum  = r_in_cnt + keep_bytes(i_data.tkeep);
    assign w_out_sum = r_out_cnt + keep_bytes(w_co_keep[r_out_sel]);
    assign i_data.tready = w_in_rdy;

    always_comb begin
        w_state    = r_state;
        w_in_sel   = r_in_sel;
        w_in_cnt   = r_in_cnt;
        w_com      = r_com;
        w_push     = 1'b0;
        w_hdr_err  = 1'b0;
        w_clen_err = 1'b0;
        w_in_rdy   = 1'b0;
        w_ci_valid = '0;
        case (r_state)
            IN_HDR: begin
                w_in_rdy = !w_fifo_full && !w_blk;
                if (i_data.tvalid && w_in_rdy) begin
                    if (i_data.tlast) begin
                        w_hdr_err = 1'b1;
                    end else if (size_ok(w_hdr.com_size) && size_ok(w_hdr.uncom_size)) begin
                        w_push   = 1'b1;
                        w_com    = w_hdr.com_size;
                        w_in_cnt = '0;
                        w_state  = IN_BODY;
                    end else begin
                        w_hdr_err = 1'b1;
                        w_state   = IN_DROP;
                    end
                end
            end
            IN_BODY: begin
                w_ci_valid[r_in_sel] = i_data.tvalid && !w_blk;
                w_in_rdy = w_ci_ready[r_in_sel] && !w_blk;
                if (i_data.tvalid && w_in_rdy) begin
                    // saturate so an oversize body can never wrap back onto com_size
                    w_in_cnt = w_in_sum > CNT_MAX ? CNT_MAX : w_in_sum;
                    if (i_data.tlast) begin
                        w_clen_err = w_in_sum != r_com;
                        w_in_sel   = wrap(r_in_sel);
                        w_state    = IN_HDR;
                    end
                end
            end
            default: begin
                w_in_rdy = !w_blk;
                if (i_data.tvalid && w_in_rdy && i_data.tlast) w_state = IN_HDR;
            end
        endcase
    end

    always_comb begin
        o_data.tdata  = w_co_data[r_out_sel];
        o_data.tkeep  = w_co_keep[r_out_sel];
        o_data.tlast  = w_co_last[r_out_sel];
        o_data.tvalid = w_co_valid[r_out_sel] && !w_fifo_empty && !w_blk;
    end

    always_comb begin
        w_out_sel  = r_out_sel;
        w_out_cnt  = r_out_cnt;
        w_pop      = 1'b0;
        w_ulen_err = 1'b0;
        w_co_ready = '0;
        w_co_ready[r_out_sel] = o_data.tready && !w_fifo_empty && !w_blk;
        if (w_co_valid[r_out_sel] && w_co_ready[r_out_sel]) begin
            w_out_cnt = w_out_sum;
            if (w_co_last[r_out_sel]) begin
                w_pop      = 1'b1;
                w_ulen_err = w_out_sum != w_fifo_head;
                w_out_cnt  = '0;
                w_out_sel  = wrap(r_out_sel);
            end
        end
    end

    always_ff @(posedge aclk) begin
        r_rst_q <= areset;
        if (areset) begin
            r_state    <= IN_HDR;
            r_in_sel   <= '0;
            r_out_sel  <= '0;
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
            r_com      <= '0;
            r_hdr_err  <= 1'b0;
            r_clen_err <= 1'b0;
            r_ulen_err <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_in_sel   <= w_in_sel;
            r_out_sel  <= w_out_sel;
            r_in_cnt   <= w_in_cnt;
            r_out_cnt  <= w_out_cnt;
            r_com      <= w_com;
            r_hdr_err  <= w_hdr_err;
            r_clen_err <= w_clen_err;
            r_ulen_err <= w_ulen_err;
        end
    end

    assign o_hdr_err  = r_hdr_err;
    assign o_clen_err = r_clen_err;
    assign o_ulen_err = r_ulen_err;
    assign o_busy     = !w_blk && (!w_fifo_empty || r_state != IN_HDR);

    decompression_arbiter_fifo #(.WIDTH(PW), .DEPTH(ORDER_FIFO_DEPTH)) u_order (
        .clk     (aclk),
        .rst     (areset),
        .i_push  (w_push),
        .i_din   (w_hdr.uncom_size),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    for (genvar c = 0; c < N_CORES; c++) begin : g_core
        axi4s #(.DATA_BITS(AXI_DATA_BITS)) w_ci ();
        axi4s #(.DATA_BITS(AXI_DATA_BITS)) w_co ();
        assign w_ci.tdata    = i_data.tdata;
        assign w_ci.tkeep    = i_data.tkeep;
        assign w_ci.tlast    = i_data.tlast;
        assign w_ci.tvalid   = w_ci_valid[c];
        assign w_ci_ready[c] = w_ci.tready;
        assign w_co_valid[c] = w_co.tvalid;
        assign w_co_data[c]  = w_co.tdata;
        assign w_co_keep[c]  = w_co.tkeep;
        assign w_co_last[c]  = w_co.tlast;
        assign w_co.tready   = w_co_ready[c];
        GunzipWrapper u_gz (
            .clk    (aclk),
            .rst_n  (!areset),
            .i_data (w_ci),
            .o_data (w_co)
        );
    end
endmodule

// File: tb/tb_decompression_arbiter.sv
// tb_decompression_arbiter: random-stimulus check of framing, ordering and error pulses against a queue model
module tb_decompression_arbiter;
    import decompression_arbiter_pkg::*;

    localparam int N  = COMP_CORES;
    localparam int DB = AXI_DATA_BITS;
    localparam int KB = AXI_KEEP_BITS;
    localparam int PW = PAGE_SIZE_WIDTH;

    typedef struct {
        logic [DB-1:0] d;
        logic [KB-1:0] k;
        logic          l;
    } beat_t;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic hdr_err, clen_err, ulen_err, busy;
    int total = 0, bad = 0;
    int n_hdr = 0, n_clen = 0, n_ulen = 0, e_hdr = 0, e_clen = 0, e_ulen = 0;
    int nfr = 0, bp_mode = 2;
    beat_t exp_q[$];
    beat_t mb;

    always #5 aclk = ~aclk;

    axi4s #(.DATA_BITS(DB)) in_if ();
    axi4s #(.DATA_BITS(DB)) out_if ();

    decompression_arbiter dut (
        .aclk       (aclk),
        .areset     (areset),
        .i_data     (in_if),
        .o_data     (out_if),
        .o_hdr_err  (hdr_err),
        .o_clen_err (clen_err),
        .o_ulen_err (ulen_err),
        .o_busy     (busy)
    );

    task automatic chk(string tag, logic [DB-1:0] got, logic [DB-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [KB-1:0] keep_of(int rem);
        return rem >= KB ? {KB{1'b1}} : (KB'(1) << rem) - KB'(1);
    endfunction

    initial begin
        out_if.tready = 1'b0;
        forever begin
            @(posedge aclk);
            #2;
            out_if.tready = bp_mode == 1 ? 1'b0 : bp_mode == 2 ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge aclk) begin
        n_hdr  += int'(hdr_err);
        n_clen += int'(clen_err);
        n_ulen += int'(ulen_err);
        if (out_if.tvalid && out_if.tready) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", 1, 0);
            end else begin
                mb = exp_q.pop_front();
                chk("page_data", out_if.tdata, mb.d);
                chk("page_keep", out_if.tkeep, mb.k);
                chk("page_last", out_if.tlast, mb.l);
            end
        end
    end

    task automatic drive_beat(logic [DB-1:0] d, logic [KB-1:0] k, logic l);
        logic ok = 1'b0;
        in_if.tdata  = d;
        in_if.tkeep  = k;
        in_if.tlast  = l;
        in_if.tvalid = 1'b1;
        for (int t = 0; t < 5000 && !ok; t++) begin
            @(negedge aclk);
            ok = in_if.tready;
            @(posedge aclk);
            #1;
        end
        in_if.tvalid = 1'b0;
        if (!ok) chk("in_stall_timeout", 1, 0);
    endtask

    // Model: a valid header queues the page the core will produce; pages leave in header order.
    task automatic send_frame(int com, int uncom, int len, int dly, int nbytes, logic [31:0] seed);
        logic [DB-1:0] d;
        beat_t eb;
        int rem;
        d = {16{$urandom}};
        d[2*PW-1:0] = {PW'(uncom), PW'(com)};
        drive_beat(d, KB'($urandom), 1'b0);
        if (com < 1 || com > PAGE_SIZE || uncom < 1 || uncom > PAGE_SIZE) begin
            e_hdr++;
        end else begin
            for (int b = 0; b == 0 || b * KB < len; b++) begin
                eb.d = {(DB/32){32'(seed + 32'(b))}};
                eb.k = keep_of(len - b * KB);
                eb.l = len - b * KB <= KB;
                exp_q.push_back(eb);
            end
            if (nbytes != com) e_clen++;
            if (len != uncom) e_ulen++;
            nfr++;
        end
        rem = nbytes;
        for (int b = 0; rem > 0; b++) begin
            d = {16{$urandom}};
            if (b == 0) d[63:0] = {seed, 16'(dly), 3'b0, PW'(len)};
            if ($urandom_range(0, 3) == 0) begin
                @(posedge aclk);
                #1;
            end
            drive_beat(d, keep_of(rem), rem <= KB);
            rem -= KB;
        end
    endtask

    task automatic drain(string tag);
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 20000) begin
            @(posedge aclk);
            #1;
            t++;
        end
        repeat (3) @(posedge aclk);
        #1;
        chk({tag, "_drained"}, exp_q.size() == 0 && !busy, 1);
        chk({tag, "_hdr_err"}, n_hdr, e_hdr);
        chk({tag, "_clen_err"}, n_clen, e_clen);
        chk({tag, "_ulen_err"}, n_ulen, e_ulen);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [DB-1:0] d;
        int len, nb;
        in_if.tvalid = 1'b1;
        in_if.tdata  = '0;
        in_if.tkeep  = '1;
        in_if.tlast  = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_in_ready", in_if.tready, 0);
        chk("rst_out_valid", out_if.tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errs", {hdr_err, clen_err, ulen_err}, 0);
        areset = 1'b0;
        chk("post_rst_in_ready", in_if.tready, 0);
        chk("post_rst_busy", busy, 0);
        in_if.tvalid = 1'b0;
        @(posedge aclk);
        #1;
        bp_mode = 0;
        send_frame(1000, 4096, 4096, 0, 1000, $urandom);
        chk("t1_beats_queued", exp_q.size() <= 64, 1);
        drain("t1");
        chk("t1_busy", busy, 0);
        for (int i = 0; i < 2 * N + 1; i++) begin
            len = $urandom_range(1, PAGE_SIZE);
            nb  = $urandom_range(8, 2000);
            send_frame(nb, len, len, (nfr % N == 0 && i < N) ? 200 : $urandom_range(0, 20), nb, $urandom);
        end
        drain("t2");
        send_frame(0, 100, 100, 0, 320, $urandom);
        d = {16{$urandom}};
        d[2*PW-1:0] = {PW'(300), PW'(200)};
        drive_beat(d, '1, 1'b1);
        e_hdr++;
        send_frame(200, 300, 300, 0, 200, $urandom);
        drain("t3");
        send_frame(1000, 1000, 1000, 0, 1064, $urandom);
        drain("t4");
        send_frame(500, 4096, 4032, 0, 500, $urandom);
        drain("t5");
        bp_mode = 1;
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) send_frame(100, 200, 200, 0, 100, $urandom);
        d = {16{$urandom}};
        d[2*PW-1:0] = {PW'(200), PW'(100)};
        drive_beat(d, '1, 1'b0);
        in_if.tdata  = {16{$urandom}};
        in_if.tlast  = 1'b0;
        in_if.tvalid = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk("t6_body_stalled", in_if.tready, 0);
        chk("t6_busy", busy, 1);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        exp_q.delete();
        nfr = 0;
        chk("t6_rst_in_ready", in_if.tready, 0);
        chk("t6_rst_out_valid", out_if.tvalid, 0);
        chk("t6_rst_busy", busy, 0);
        in_if.tvalid = 1'b0;
        bp_mode = 0;
        @(posedge aclk);
        #1;
        send_frame(700, 1500, 1500, 5, 700, $urandom);
        drain("t6");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
